// File: rtl/spi_frame_ctrl.sv
// Single-clock receiver for the 128-bit MCU keypoint frame: oversampled SPI capture,
// sync/checksum validation, and a pending buffer that is committed on vsync.
// Optional build macro: SPI_FRAME_CHECKSUM_EN also requires the XOR checksum to match.
module spi_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             sdi,
  input  logic             load,
  input  logic             vsync,
  output logic [9:0]       x_1,
  output logic [9:0]       y_1,
  output logic [9:0]       x_2,
  output logic [9:0]       y_2,
  output logic [9:0]       x_3,
  output logic [9:0]       y_3,
  output logic [9:0]       x_4,
  output logic [9:0]       y_4,
  output logic [3:0]       r,
  output logic [3:0]       g,
  output logic [3:0]       b,
  output logic             busy,
  output logic             done,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             updated,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;

  state_t         state, state_nx;
  logic [2:0]     sck_sync;
  logic [1:0]     sdi_sync;
  logic [1:0]     load_sync;
  logic           sck_rise;
  logic           load_s;
  logic           sdi_s;
  logic [127:0]   shreg;
  logic [6:0]     bit_cnt;
  logic [91:0]    pend_data;
  logic           pend_valid;
  logic [91:0]    out_data;

  logic           clr_shift, do_shift, abort, check;
  logic           sync_ok, sum_ok, frame_pass, frame_fail;

  // Two flops per pin for metastability; the third sck flop only serves edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge value;
      // blocking would collapse the synchronizer chain into a single stage.
      sck_sync  <= {sck_sync[1:0], sck};
      sdi_sync  <= {sdi_sync[0], sdi};
      load_sync <= {load_sync[0], load};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sdi_s    = sdi_sync[1];
  assign load_s   = load_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; a missing branch
    // would otherwise infer a latch.
    state_nx  = state;
    clr_shift = 1'b0;
    do_shift  = 1'b0;
    abort     = 1'b0;
    check     = 1'b0;
    case (state)
      IDLE: begin
        if (load_s) begin
          state_nx  = SHIFT;
          clr_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (!load_s) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end else if (sck_rise) begin
          do_shift = 1'b1;
          if (bit_cnt == 7'd127) state_nx = CHECK;
        end
      end
      CHECK: begin
        check    = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        if (!load_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SHIFT) || (state == CHECK);
  assign done = (state == DONE);

  assign sync_ok = (shreg[127:120] == SYNC_BYTE);

`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0] xor_acc;
  always_comb begin
    xor_acc = 8'h00;
    for (int i = 1; i < 16; i++) xor_acc = xor_acc ^ shreg[8*i +: 8];
  end
  assign sum_ok = (xor_acc == shreg[7:0]);
`else
  assign sum_ok = 1'b1;
`endif

  assign frame_pass = check & sync_ok & sum_ok;
  assign frame_fail = abort | (check & ~(sync_ok & sum_ok));

  // NOTE: the 128-bit shift register and pending buffer are plain flops, so they are
  // reset along with everything else; no RAM inference is intended here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      out_data   <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      updated    <= 1'b0;
      ok_count   <= '0;
      err_count  <= '0;
    end else begin
      frame_ok  <= frame_pass;
      frame_err <= frame_fail;
      updated   <= 1'b0;

      if (clr_shift) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (do_shift) begin
        shreg   <= {shreg[126:0], sdi_s};
        bit_cnt <= bit_cnt + 7'd1;
      end

      // Commit first; a same-cycle accept below then refills pending and re-arms it.
      if (vsync && pend_valid) begin
        out_data   <= pend_data;
        pend_valid <= 1'b0;
        updated    <= 1'b1;
      end
      if (frame_pass) begin
        pend_data  <= shreg[119:28];
        pend_valid <= 1'b1;
      end

      if (frame_pass && (ok_count != {CNT_W{1'b1}}))  ok_count  <= ok_count + 1'b1;
      if (frame_fail && (err_count != {CNT_W{1'b1}})) err_count <= err_count + 1'b1;
    end
  end

  assign x_1 = out_data[91:82];
  assign y_1 = out_data[81:72];
  assign x_2 = out_data[71:62];
  assign y_2 = out_data[61:52];
  assign x_3 = out_data[51:42];
  assign y_3 = out_data[41:32];
  assign x_4 = out_data[31:22];
  assign y_4 = out_data[21:12];
  assign r   = out_data[11:8];
  assign g   = out_data[7:4];
  assign b   = out_data[3:0];

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl; expectations follow SPI_FRAME_CHECKSUM_EN when defined.
module tb_spi_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, sck, sdi, load, vsync;
  logic [9:0] x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4;
  logic [3:0] r, g, b;
  logic       busy, done, frame_ok, frame_err, updated;
  logic [7:0] ok_count, err_count;

  int errors = 0;
  int checks = 0;
  int n_ok = 0, n_err = 0, n_upd = 0;
  int exp_ok = 0, exp_err = 0, exp_upd = 0;
  logic [91:0]  exp_out;
  logic [127:0] fa, fb, fc, fd, fe, ff, fbad;

  spi_frame_ctrl dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load), .vsync(vsync),
    .x_1(x_1), .y_1(y_1), .x_2(x_2), .y_2(y_2), .x_3(x_3), .y_3(y_3), .x_4(x_4), .y_4(y_4),
    .r(r), .g(g), .b(b), .busy(busy), .done(done), .frame_ok(frame_ok),
    .frame_err(frame_err), .updated(updated), .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Pulse counters: a pulse held for more than one cycle is counted more than once.
  always @(negedge clk) begin
    if (frame_ok)  n_ok++;
    if (frame_err) n_err++;
    if (updated)   n_upd++;
  end

  wire [91:0] outs = {x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4, r, g, b};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] s, input logic [79:0] c,
                                      input logic [11:0] rgb, input logic flip);
    logic [127:0] f;
    logic [7:0]   x;
    f = {s, c, rgb, 20'h12345, 8'h00};
    x = 8'h00;
    for (int i = 1; i < 16; i++) x = x ^ f[8*i +: 8];
    f[7:0] = x ^ {7'b0, flip};
    return f;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sck phases are 3 clk periods each, changes aligned to clk falling edges.
  task automatic send_bits(input logic [127:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 128) ? f[127-i] : 1'b0;
      #30 sck = 1'b1;
      #30 sck = 1'b0;
    end
  endtask

  task automatic full_frame(input logic [127:0] f, input int nbits);
    load = 1'b1;
    wait_clk(4);
    send_bits(f, nbits);
    wait_clk(10);
  endtask

  task automatic drop_load;
    load = 1'b0;
    wait_clk(6);
  endtask

  task automatic pulse_vsync;
    vsync = 1'b1;
    wait_clk(1);
    vsync = 1'b0;
    wait_clk(3);
  endtask

  task automatic check_counts(input string tag);
    check({tag, ".ok_count"},  ok_count,  exp_ok);
    check({tag, ".err_count"}, err_count, exp_err);
    check({tag, ".ok_pulses"}, n_ok,      exp_ok);
    check({tag, ".err_pulses"}, n_err,    exp_err);
  endtask

  initial begin
    reset_n = 1'b0; sck = 1'b0; sdi = 1'b0; load = 1'b0; vsync = 1'b0;
    fa   = mk(8'hA5, {10'h155, 10'h2AA, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006},
              {4'hF, 4'h0, 4'h5}, 1'b0);
    fbad = mk(8'hA4, {10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066, 10'h077, 10'h088},
              {4'h1, 4'h2, 4'h3}, 1'b0);
    fb   = mk(8'hA5, {10'h3FF, 10'h200, 10'h100, 10'h080, 10'h040, 10'h020, 10'h010, 10'h008},
              {4'hA, 4'hB, 4'hC}, 1'b1);
    fc   = mk(8'hA5, {10'h0AA, 10'h155, 10'h3C3, 10'h03C, 10'h111, 10'h222, 10'h333, 10'h000},
              {4'h7, 4'h8, 4'h9}, 1'b0);
    fd   = mk(8'hA5, {10'h001, 10'h001, 10'h001, 10'h001, 10'h001, 10'h001, 10'h001, 10'h001},
              {4'h1, 4'h1, 4'h1}, 1'b0);
    fe   = mk(8'hA5, {10'h2F0, 10'h10F, 10'h0F0, 10'h30F, 10'h1E1, 10'h21E, 10'h0C3, 10'h33C},
              {4'hE, 4'hD, 4'h6}, 1'b0);
    ff   = mk(8'hA5, {10'h123, 10'h321, 10'h0DE, 10'h2AD, 10'h0BE, 10'h0EF, 10'h3FE, 10'h1FF},
              {4'h4, 4'hC, 4'h2}, 1'b0);

    // Reset state
    wait_clk(3);
    check("reset.outs", outs, 92'h0);
    check("reset.busy_done", {busy, done}, 2'b00);
    check_counts("reset");
    reset_n = 1'b1;
    wait_clk(2);

    // Valid frame A: accepted, outputs held until vsync
    full_frame(fa, 128);
    exp_ok++;
    check("A.done", {busy, done}, 2'b01);
    check_counts("A");
    check("A.outs_pre_vsync", outs, 92'h0);
    drop_load();
    check("A.idle", {busy, done}, 2'b00);
    pulse_vsync();
    exp_upd++; exp_out = fa[119:28];
    check("A.outs", outs, exp_out);
    check("A.x_1", x_1, 10'h155);
    check("A.rgb", {r, g, b}, 12'hF05);
    check("A.updated", n_upd, exp_upd);

    // Bad sync byte: rejected, pending stays empty so vsync does nothing
    full_frame(fbad, 128);
    exp_err++;
    check_counts("sync");
    drop_load();
    pulse_vsync();
    check("sync.outs", outs, exp_out);
    check("sync.updated", n_upd, exp_upd);

    // Checksum bit 0 flipped
    full_frame(fb, 128);
    drop_load();
`ifdef SPI_FRAME_CHECKSUM_EN
    exp_err++;
`else
    exp_ok++;
    exp_upd++; exp_out = fb[119:28];
`endif
    check_counts("cks");
    pulse_vsync();
    check("cks.outs", outs, exp_out);
    check("cks.updated", n_upd, exp_upd);

    // Abort after 60 bits, then a normal frame
    load = 1'b1;
    wait_clk(4);
    check("abort.busy", busy, 1'b1);
    send_bits(fc, 60);
    drop_load();
    exp_err++;
    check_counts("abort");
    check("abort.idle", {busy, done}, 2'b00);
    full_frame(fc, 128);
    drop_load();
    exp_ok++;
    check_counts("C");
    pulse_vsync();
    exp_upd++; exp_out = fc[119:28];
    check("C.outs", outs, exp_out);

    // Two frames without vsync; second one carries 2 extra sck edges
    full_frame(fd, 128);
    drop_load();
    full_frame(fe, 130);
    check("E.done_after_extra", done, 1'b1);
    drop_load();
    exp_ok += 2;
    check_counts("DE");
    check("DE.outs_pre_vsync", outs, exp_out);
    pulse_vsync();
    exp_upd++; exp_out = fe[119:28];
    check("DE.outs", outs, exp_out);
    check("DE.updated", n_upd, exp_upd);

    // Reset mid-SHIFT at bit 90
    load = 1'b1;
    wait_clk(4);
    send_bits(ff, 90);
    reset_n = 1'b0;
    #1;
    check("rst.outs", outs, 92'h0);
    check("rst.counts", {ok_count, err_count}, 16'h0);
    check("rst.busy", busy, 1'b0);
    load = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(2);
    n_ok = 0; n_err = 0; n_upd = 0;
    exp_ok = 0; exp_err = 0; exp_upd = 0;
    full_frame(ff, 128);
    drop_load();
    exp_ok++;
    check_counts("F");
    pulse_vsync();
    exp_upd++; exp_out = ff[119:28];
    check("F.outs", outs, exp_out);
    check("F.updated", n_upd, exp_upd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

Clock-domain receive controller for the MCU-to-FPGA 128-bit keypoint frame. It oversamples `sck`/`sdi`/`load` on the system clock, sequences frame capture, and validates the sync byte and checksum. Accepted frames are double-buffered so that the renderer only sees new coordinates at a `vsync` boundary. It sits between the SPI pins and the drawing logic, and replaces the `sck`-clocked capture path with a single-clock design.

## Interface
- `SYNC_BYTE`, 8'hA5, required value of frame bits [127:120]
- `CNT_W`, 8, width of the saturating frame counters
- `clk`  in  1  system clock (internal oscillator)
- `reset_n`  in  1  asynchronous, active-low reset
- `sck`  in  1  SPI clock from MCU, asynchronous to `clk`
- `sdi`  in  1  SPI data, MSB first, sampled on `sck` rising
- `load`  in  1  frame window from MCU, high for the whole 128-bit transfer
- `vsync`  in  1  one-cycle strobe from the renderer marking a safe update point
- `x_1`,`y_1`,`x_2`,`y_2`,`x_3`,`y_3`,`x_4`,`y_4`  out  10 each  committed keypoint coordinates
- `r`,`g`,`b`  out  4 each  committed colour
- `busy`  out  1  high in SHIFT and CHECK
- `done`  out  1  high in DONE (frame fully received, awaiting `load` low)
- `frame_ok`  out  1  one-cycle pulse: frame accepted into pending buffer
- `frame_err`  out  1  one-cycle pulse: frame rejected or aborted
- `updated`  out  1  one-cycle pulse: outputs loaded from pending buffer
- `ok_count`  out  CNT_W  accepted frames, saturating
- `err_count`  out  CNT_W  rejected or aborted frames, saturating

## Operation
- Frame layout, MSB first:
  - [127:120] sync byte
  - [119:40] x_1,y_1,x_2,y_2,x_3,y_3,x_4,y_4
  - [39:28] r,g,b
  - [27:8] reserved, ignored
  - [7:0] checksum equal to the XOR of bytes [127:8]
- Input path: `sck`, `sdi` and `load` each pass through a 2-flop synchronizer. A third `sck` register provides rising-edge detection.
- States:
  - IDLE: synced `load` high → SHIFT, with the shift register and 7-bit bit counter cleared.
  - SHIFT: on each detected `sck` rise, shift in synced `sdi` and increment the counter. When the counter wraps from 127, go to CHECK. Synced `load` low → IDLE, pulse `frame_err`, increment `err_count`.
  - CHECK (1 cycle): on sync and checksum match, write the pending buffer, set `pend_valid`, pulse `frame_ok` and increment `ok_count`. Otherwise pulse `frame_err` and increment `err_count`. Either way go to DONE.
  - DONE: ignore `sck` edges. Synced `load` low → IDLE.
- Commit: on `vsync` with `pend_valid`=1, outputs ← pending, `pend_valid` ← 0, and `updated` pulses. `vsync` with `pend_valid`=0 does nothing.
- A new accepted frame overwrites an uncommitted pending frame. The older frame is lost and not counted.
- Simultaneous CHECK-pass and `vsync`:
  - If `pend_valid` was already 1, the old pending data is committed and the new frame is written to pending; `pend_valid` stays 1.
  - If `pend_valid` was 0, nothing is committed that cycle.
- Counters saturate at all-ones. They do not wrap.
- Reset values:
  - state IDLE; all outputs 0.
  - `pend_valid`=0; shift register and counters 0.

## Timing
- `sck` high and low phases must each last ≥ 2 `clk` periods. `load` must rise ≥ 2 `clk` periods before the first `sck` rise.
- Latency: a bit is shifted on the 3rd `clk` edge after its `sck` rise at the pin. CHECK occupies the next cycle. `frame_ok`/`frame_err` are registered and high in the cycle after CHECK.
- `updated` and the new output values appear on the `clk` edge after `vsync` is sampled.
- `reset_n` low at any point clears all state immediately, including mid-frame. No error is counted.

## Configuration
- `SPI_FRAME_CHECKSUM_EN` defined: CHECK requires both the sync byte match and the XOR checksum match.
- Undefined: CHECK requires only the sync byte match. Bits [7:0] are ignored and the checksum logic is not built.

## Test plan
- Valid frame, then `vsync`: sync A5, x_1=10'h155, y_1=10'h2AA, remaining coords 10'h001…10'h006, r/g/b=4'hF/4'h0/4'h5, correct checksum → `frame_ok` pulse, `ok_count`=1. Outputs stay at 0 until `vsync`, then take exactly those values with one `updated` pulse.
- Sync byte 8'hA4, otherwise valid → `frame_err` pulse, `err_count`=1, outputs and `pend_valid` unchanged.
- Checksum bit 0 flipped → with macro: `frame_err`, `err_count`+1. Without macro: `frame_ok`.
- `load` dropped after 60 bits → return to IDLE, `frame_err` pulse, `err_count`+1. The following full valid frame is accepted normally.
- Two valid frames A then B with no `vsync` between, then `vsync` → outputs show B only, `ok_count`=2, one `updated` pulse. A 130-edge burst in a single `load` window is handled as one frame, with the extra edges ignored in DONE.
- `reset_n` asserted mid-SHIFT at bit 90 → all outputs and counters 0. After release, a valid frame is accepted with `ok_count`=1.
